fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction buffer between the fetch stage and the dual-issue decode stage of the superscalar in-order core. It accepts up to two `fetch_data_t` entries per cycle from fetch (instruction word, PC+4, branch prediction, fetch exception) and presents the two oldest entries, in program order, to the two decoder slots. Decode consumes 0, 1 or 2 entries per cycle. The block provides first-word-fall-through FIFO storage with a flush for redirects.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two, at least 4.

Ports:
- `clk`  in  1: the only clock. All state changes on the rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `flush`  in  1: discards all entries. Used on mispredict, exception or eret redirect.
- `push_cnt`  in  2: number of fetch entries offered this cycle, 0..2. A value of 3 is treated as 2.
- `push_data0`  in  `fetch_data_t`: older offered entry.
- `push_data1`  in  `fetch_data_t`: younger offered entry. Valid only when `push_cnt` is 2.
- `in_ready`  out  1: high when at least 2 entries are free.
- `pop_cnt`  in  2: entries consumed by decode this cycle, 0..2. A value of 3 is treated as 2.
- `out_valid`  out  2: bit0 = slot0 holds data, bit1 = slot1 holds data.
- `out_data0`  out  `fetch_data_t`: oldest entry.
- `out_data1`  out  `fetch_data_t`: second-oldest entry.

## Operation
- State:
  - `head` and `tail` pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
  - Storage array of DEPTH entries. The array is not reset.
- Accepted push:
  - `push_acc` = `push_cnt` if `in_ready`, else 0. Offers made while `in_ready` is low are dropped entirely, with no partial accept.
  - Fetch must hold its PC while `in_ready` is low.
  - Writes: `push_data0` goes to mem[tail]. If `push_acc` is 2, `push_data1` also goes to mem[tail+1].
- Effective pop:
  - `pop_eff` = min(`pop_cnt`, `count`). Popping more entries than are present is clamped, not an error.
- Next state when no flush and `resetn` is high:
  - `head` += `pop_eff`
  - `tail` += `push_acc`
  - `count` = `count` − `pop_eff` + `push_acc`
- Pop and push in the same cycle are legal. `in_ready` is evaluated on the current `count` and does not include space freed by this cycle's pop. This keeps it free of a combinational path from `pop_cnt`.
- `flush` priority: `resetn` low > `flush` > push/pop.
  - On flush, `head`, `tail` and `count` all become 0.
  - Any push or pop in the same cycle is ignored.
- Outputs are combinational from registered state only (first-word fall-through):
  - `out_valid[0]` = (`count` ≥ 1); `out_valid[1]` = (`count` ≥ 2).
  - `out_data0` = mem[head]; `out_data1` = mem[head+1], wrapping modulo DEPTH.
  - Data outputs are don't-care when the matching `out_valid` bit is low.
  - `in_ready` = (DEPTH − `count` ≥ 2).
- Order is strict: entries leave in the same order they arrived, slot0 before slot1 within a cycle.

## Timing
- Reset values, one cycle after `resetn` is sampled low: `head`=`tail`=`count`=0, `out_valid`=2'b00, `in_ready`=1.
- Latency: an entry accepted at edge N is visible on `out_data0`/`out_data1` with `out_valid` set in the cycle following edge N. There is no bypass of push data directly to the outputs.
- Throughput: a sustained 2 in / 2 out per cycle is possible when `count` ≤ DEPTH−2.
- Full: at `count` = DEPTH−1 or DEPTH, `in_ready` is 0. A single-entry push is also refused when only one slot is free. This is deliberate, to keep paired fetch granules intact.
- Empty: at `count` = 0, `out_valid` is 00 and any `pop_cnt` does nothing.
- Wrap-around: pointers wrap silently. `out_data1` reads mem[0] when `head` = DEPTH−1.
- Reset mid-operation: all contents are lost; behaviour is identical to power-up reset. A flush asserted in the same cycle as `resetn` low has no additional effect.
- Flush: outputs are invalid in the cycle after the flush edge. A push in the cycle after flush is accepted normally.

## Test plan
- **Reset:** hold `resetn` low 2 cycles with `push_cnt`=2 → `out_valid`=00, `in_ready`=1, `count`=0 afterwards; nothing was stored.
- **Fill and drain:** push pairs with pcplus4 = 0x..04/08, 0C/10, 14/18, and so on, with `pop_cnt`=0.
  - After 3 pairs (DEPTH=8), `in_ready` stays 1.
  - After the 4th pair, `count`=8 and `in_ready`=0.
  - A further push is dropped: `count` stays 8.
  - Then `pop_cnt`=2 per cycle → `out_data0`/`out_data1` show 04/08, 0C/10, ... in order; `out_valid` reaches 00 after 4 cycles.
- **Odd counts and wrap:** alternate `push_cnt`=1 and `pop_cnt`=1 so that `head` crosses 7→0 → no reordering. With `count`=1 and `pop_cnt`=2, only one entry is removed and `count` becomes 0.
- **Simultaneous push and pop at `count`=6:** `push_cnt`=2, `pop_cnt`=2 → accepted, `count` stays 6. At `count`=7, the push is refused while the pop still succeeds, so `count` becomes 5.
- **Flush:** with `count`=5, assert `flush` together with `push_cnt`=2 and `pop_cnt`=1 → next cycle `count`=0, `out_valid`=00. A push the following cycle shows its new data at `out_data0` one cycle later.
- **Field integrity:** push entries with `pred` and `exception_instr` set to distinct patterns → every field emerges bit-exact on the same slot as its `instr_`.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: dual-in / dual-out first-word-fall-through instruction buffer between fetch and decode
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] instr_;
        logic [31:0] pcplus4;
        logic [3:0]  pred;
        logic [3:0]  exception_instr;
    } fetch_data_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [1:0]  push_cnt,
    input  fetch_data_t push_data0,
    input  fetch_data_t push_data1,
    output logic        in_ready,
    input  logic [1:0]  pop_cnt,
    output logic [1:0]  out_valid,
    output fetch_data_t out_data0,
    output fetch_data_t out_data1
);
    localparam int AW = $clog2(DEPTH);

    fetch_data_t   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_nx, tail_nx;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    push_n, pop_n, push_acc, pop_eff;

    // accepted push / clamped pop and next pointer state; flush wins over traffic
    always_comb begin
        push_n   = (push_cnt == 2'd3) ? 2'd2 : push_cnt;
        pop_n    = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        in_ready = count_q <= (AW+1)'(DEPTH - 2);
        push_acc = in_ready ? push_n : 2'd0;
        pop_eff  = (count_q < (AW+1)'(pop_n)) ? count_q[1:0] : pop_n;
        head_nx  = head_q + AW'(1);
        tail_nx  = tail_q + AW'(1);
        head_d   = flush ? '0 : head_q + AW'(pop_eff);
        tail_d   = flush ? '0 : tail_q + AW'(push_acc);
        count_d  = flush ? '0 : count_q - (AW+1)'(pop_eff) + (AW+1)'(push_acc);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // storage is never reset; only accepted entries are written
    always_ff @(posedge clk) begin
        if (resetn && !flush && push_acc != 2'd0) mem_q[tail_q] <= push_data0;
        if (resetn && !flush && push_acc == 2'd2) mem_q[tail_nx] <= push_data1;
    end

    // fall-through outputs straight from registered state
    always_comb begin
        out_valid = {count_q >= (AW+1)'(2), count_q != '0};
        out_data0 = mem_q[head_q];
        out_data1 = mem_q[head_nx];
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with directed vectors
module tb_fetch_queue;
    import fetch_queue_pkg::*;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  push_cnt = 2'd0;
    logic [1:0]  pop_cnt = 2'd0;
    logic [1:0]  out_valid;
    logic        in_ready;
    fetch_data_t push_data0 = '0;
    fetch_data_t push_data1 = '0;
    fetch_data_t out_data0, out_data1;

    fetch_data_t sb[$];
    fetch_data_t pend[$];
    int          total = 0;
    int          bad = 0;
    int          pe;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .push_cnt(push_cnt), .push_data0(push_data0), .push_data1(push_data1),
        .in_ready(in_ready), .pop_cnt(pop_cnt), .out_valid(out_valid),
        .out_data0(out_data0), .out_data1(out_data1)
    );

    function automatic fetch_data_t mk(input logic [31:0] pc);
        fetch_data_t e;
        e.instr_          = {8'h13, pc[23:0]};
        e.pcplus4         = pc;
        e.pred            = pc[5:2] ^ 4'h5;
        e.exception_instr = ~pc[5:2] ^ pc[9:6];
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference queue update at each edge, mirroring the accepted traffic
    always @(posedge clk) begin
        if (!resetn || flush) begin
            sb.delete();
            pend.delete();
        end else begin
            pe = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
            if (pe > sb.size()) pe = sb.size();
            repeat (pe) void'(sb.pop_front());
            while (pend.size() > 0) sb.push_back(pend.pop_front());
        end
    end

    // monitor: compare presented outputs with the scoreboard away from the edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", 128'(out_valid), 128'({sb.size() >= 2, sb.size() >= 1}));
            check("mon_in_ready", 128'(in_ready), 128'(sb.size() <= DEPTH - 2));
            if (sb.size() >= 1) check("mon_data0", 128'(out_data0), 128'(sb[0]));
            if (sb.size() >= 2) check("mon_data1", 128'(out_data1), 128'(sb[1]));
        end
    end

    task automatic step(input int pn, input logic [31:0] pc0, input logic [31:0] pc1,
                        input int popn, input bit fl);
        push_cnt   = 2'(pn);
        push_data0 = mk(pc0);
        push_data1 = mk(pc1);
        pop_cnt    = 2'(popn);
        flush      = fl;
        if (resetn && !fl && sb.size() <= DEPTH - 2) begin
            if (pn >= 1) pend.push_back(mk(pc0));
            if (pn >= 2) pend.push_back(mk(pc1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        step(2, 32'h904, 32'h908, 0, 0);
        mon_en = 1'b1;
        step(2, 32'h904, 32'h908, 0, 0);
        check("rst_valid", 128'(out_valid), 128'(2'b00));
        check("rst_ready", 128'(in_ready), 128'(1'b1));
        resetn = 1'b1;
        step(0, 0, 0, 2, 0);
        check("rst_empty", 128'(out_valid), 128'(2'b00));

        for (int i = 0; i < 3; i++) step(2, 32'h04 + 32'(i * 8), 32'h08 + 32'(i * 8), 0, 0);
        check("fill3_ready", 128'(in_ready), 128'(1'b1));
        step(2, 32'h1c, 32'h20, 0, 0);
        check("fill4_ready", 128'(in_ready), 128'(1'b0));
        check("fill4_valid", 128'(out_valid), 128'(2'b11));
        step(2, 32'h24, 32'h28, 0, 0);
        check("full_drop_ready", 128'(in_ready), 128'(1'b0));
        for (int i = 0; i < 4; i++) begin
            check("drain_d0", 128'(out_data0.pcplus4), 128'(32'h04 + 32'(i * 8)));
            check("drain_d1", 128'(out_data1.pcplus4), 128'(32'h08 + 32'(i * 8)));
            step(0, 0, 0, 2, 0);
        end
        check("drain_valid", 128'(out_valid), 128'(2'b00));

        step(1, 32'h100, 0, 0, 0);
        for (int i = 1; i < 11; i++) begin
            check("wrap_d0", 128'(out_data0.pcplus4), 128'(32'h100 + 32'((i - 1) * 4)));
            step(1, 32'h100 + 32'(i * 4), 0, 1, 0);
        end
        check("wrap_valid", 128'(out_valid), 128'(2'b01));
        step(0, 0, 0, 2, 0);
        check("overpop_valid", 128'(out_valid), 128'(2'b00));
        step(0, 0, 0, 3, 0);
        check("empty_pop", 128'(out_valid), 128'(2'b00));

        for (int i = 0; i < 3; i++) step(2, 32'h200 + 32'(i * 8), 32'h204 + 32'(i * 8), 0, 0);
        step(2, 32'h218, 32'h21c, 2, 0);
        check("c6_ready", 128'(in_ready), 128'(1'b1));
        check("c6_d0", 128'(out_data0.pcplus4), 128'(32'h208));
        step(1, 32'h220, 0, 0, 0);
        check("c7_ready", 128'(in_ready), 128'(1'b0));
        step(3, 32'h224, 32'h228, 2, 0);
        check("c5_ready", 128'(in_ready), 128'(1'b1));
        check("c5_d0", 128'(out_data0.pcplus4), 128'(32'h210));

        step(2, 32'h230, 32'h234, 1, 1);
        check("flush_valid", 128'(out_valid), 128'(2'b00));
        check("flush_ready", 128'(in_ready), 128'(1'b1));
        step(1, 32'h300, 0, 0, 0);
        check("post_flush_valid", 128'(out_valid), 128'(2'b01));
        check("post_flush_d0", 128'(out_data0.pcplus4), 128'(32'h300));

        step(2, 32'h3c4, 32'h0a8, 1, 0);
        step(2, 32'h15c, 32'h2f0, 0, 0);
        check("field_d0", 128'(out_data0), 128'(mk(32'h3c4)));
        check("field_d1", 128'(out_data1), 128'(mk(32'h0a8)));
        step(0, 0, 0, 2, 0);
        check("field_pred", 128'(out_data0.pred), 128'(4'h2));
        check("field_exc", 128'(out_data1.exception_instr), 128'(4'h8));
        step(0, 0, 0, 3, 0);
        check("final_valid", 128'(out_valid), 128'(2'b00));
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
